// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between fetch and decode.
// Buffers {pc, instr} pairs in a DEPTH-entry FIFO so that decode stalls
// do not stall PC generation. A redirect flush drops every queued entry.
//
// Optional build macro: FETCH_QUEUE_BYPASS_EN
//   When defined, an empty queue forwards in_pc/in_instr to the output in
//   the same cycle. If decode takes the entry in that cycle, the entry is
//   never written to storage. Otherwise it is stored as a normal push.
//   When the macro is undefined, no combinational path runs from input to output.
//
// Handshake: both sides use strict valid/ready semantics. A transfer happens
// on a rising edge where valid and ready are both 1 and flush is 0. A
// producer that raises valid must hold its data stable until the transfer
// happens. in_ready depends only on queue state and never on out_ready, so a
// full queue cannot accept a push in the same cycle that it pops.

module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    // Each pointer carries an extra wrap bit above the index bits. The wrap
    // bit tells a full queue from an empty one.
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;

    logic            empty;
    logic            full;
    logic            push;
    logic            pop_mem;
    logic            bypass_take;

    // Storage is not reset. Data is meaningful only between the pointers.
    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [XLEN-1:0] mem_instr [DEPTH];

    // Derive occupancy, handshake qualifiers and the visible head entry from pointer state.
    always_comb begin
        wr_idx   = wr_ptr[AW-1:0];
        rd_idx   = rd_ptr[AW-1:0];
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
        count    = wr_ptr - rd_ptr;
        in_ready = ~full;

`ifdef FETCH_QUEUE_BYPASS_EN
        // When the queue is empty, the incoming entry is presented directly to decode.
        bypass_take = empty & ~flush & in_valid & out_ready;
        out_valid   = ~empty | (~flush & in_valid);
        if (!empty) begin
            out_pc    = mem_pc[rd_idx];
            out_instr = mem_instr[rd_idx];
        end else if (!flush && in_valid) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end else begin
            out_pc    = '0;
            out_instr = '0;
        end
`else
        bypass_take = 1'b0;
        out_valid   = ~empty;
        if (!empty) begin
            out_pc    = mem_pc[rd_idx];
            out_instr = mem_instr[rd_idx];
        end else begin
            out_pc    = '0;
            out_instr = '0;
        end
`endif

        // Flush overrides both sides. A bypassed entry skips storage entirely.
        push    = in_valid & in_ready & ~flush & ~bypass_take;
        pop_mem = ~empty & out_ready & ~flush;
    end

    // Write an accepted entry into the slot under the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_idx]    <= in_pc;
            mem_instr[wr_idx] <= in_instr;
        end
    end

    // Advance the pointers. A flush collapses the read pointer onto the write pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_mem) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven vectors plus hand-written corner sequences for
// fetch_queue. A scoreboard queue holds the expected {pc, instr} entries.

module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic [2:0]      count;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    // Clock and reset generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ordy;
        logic        fl;
        int          cnt;   // count expected before this cycle's edge
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] exp_q[$];  // {pc, instr} in push order
    int          n_checks;
    int          n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                           input logic ordy, input logic fl, input int cnt);
        vec_t v;
        v.iv = iv; v.pc = pc; v.instr = ins; v.ordy = ordy; v.fl = fl; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // One clock cycle. Drive the inputs, check on the falling edge, update the scoreboard, and advance.
    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input int cnt);
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eins;
        bit          take;
        bit          can_push;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            ev = 1'b1; epc = exp_q[0][63:32]; eins = exp_q[0][31:0];
        end else if (BYP && iv && !fl) begin
            ev = 1'b1; epc = pc; eins = ins;
        end else begin
            ev = 1'b0; epc = '0; eins = '0;
        end
        check("out_valid", 64'(out_valid), 64'(ev));
        check("out_pc", 64'(out_pc), 64'(epc));
        check("out_instr", 64'(out_instr), 64'(eins));
        check("count", 64'(count), 64'(cnt));
        check("in_ready", 64'(in_ready), 64'(cnt < DEPTH));
        if (fl) begin
            exp_q.delete();
        end else begin
            take     = BYP && (exp_q.size() == 0) && iv && ordy;
            can_push = iv && (exp_q.size() < DEPTH) && !take;
            if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
            if (can_push) exp_q.push_back({pc, ins});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;

        // Hold reset for three cycles, then release it away from the edge.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 0);

        // Fill to DEPTH, hold off a fifth push, then drain in order.
        add_vec(1'b1, 32'h00, 32'h13, 1'b0, 1'b0, 0);
        add_vec(1'b1, 32'h04, 32'h14, 1'b0, 1'b0, 1);
        add_vec(1'b1, 32'h08, 32'h15, 1'b0, 1'b0, 2);
        add_vec(1'b1, 32'h0C, 32'h16, 1'b0, 1'b0, 3);
        add_vec(1'b1, 32'h10, 32'h17, 1'b0, 1'b0, 4);
        add_vec(1'b1, 32'h10, 32'h17, 1'b1, 1'b0, 4);
        add_vec(1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 3);
        add_vec(1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 2);
        add_vec(1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 1);
        add_vec(1'b0, 32'h00, 32'h00, 1'b0, 1'b0, 0);
        // Reach count 2, then push and pop together for six cycles so the pointers wrap.
        add_vec(1'b1, 32'h200, 32'h30, 1'b0, 1'b0, 0);
        add_vec(1'b1, 32'h204, 32'h31, 1'b0, 1'b0, 1);
        for (int k = 2; k < 8; k++)
            add_vec(1'b1, 32'h200 + 32'(4 * k), 32'h30 + 32'(k), 1'b1, 1'b0, 2);
        add_vec(1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 2);
        add_vec(1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 1);
        add_vec(1'b0, 32'h00, 32'h00, 1'b0, 1'b0, 0);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].iv, vecs[i].pc, vecs[i].instr, vecs[i].ordy, vecs[i].fl, vecs[i].cnt);

        // Flush at count 3 with a concurrent push. Entry 0x40 must be dropped.
        step(1'b1, 32'h30, 32'h50, 1'b0, 1'b0, 0);
        step(1'b1, 32'h34, 32'h51, 1'b0, 1'b0, 1);
        step(1'b1, 32'h38, 32'h52, 1'b0, 1'b0, 2);
        step(1'b1, 32'h40, 32'h53, 1'b0, 1'b1, 3);
        step(1'b1, 32'h80, 32'h54, 1'b0, 1'b0, 0);
        step(1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 1);
        step(1'b0, 32'h00, 32'h00, 1'b0, 1'b0, 0);
        // Hold flush for several cycles. It blocks pushes and keeps the queue empty.
        step(1'b1, 32'h90, 32'h55, 1'b0, 1'b1, 0);
        step(1'b1, 32'h94, 32'h56, 1'b1, 1'b1, 0);
        step(1'b0, 32'h00, 32'h00, 1'b0, 1'b0, 0);

        // Back-pressure. The head must stay stable while decode stalls.
        step(1'b1, 32'h20, 32'h60, 1'b0, 1'b0, 0);
        step(1'b1, 32'h24, 32'h61, 1'b0, 1'b0, 1);
        repeat (5) step(1'b0, 32'h00, 32'h00, 1'b0, 1'b0, 2);
        step(1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 2);
        step(1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 1);
        step(1'b0, 32'h00, 32'h00, 1'b0, 1'b0, 0);

        // Assert reset asynchronously mid-fill. The outputs must clear before the next edge.
        step(1'b1, 32'hA0, 32'h70, 1'b0, 1'b0, 0);
        step(1'b1, 32'hA4, 32'h71, 1'b0, 1'b0, 1);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst out_valid", 64'(out_valid), 64'd0);
        check("async_rst count", 64'(count), 64'd0);
        check("async_rst in_ready", 64'(in_ready), 64'd1);
        check("async_rst out_pc", 64'(out_pc), 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 32'h00, 32'h00, 1'b0, 1'b0, 0);

`ifdef FETCH_QUEUE_BYPASS_EN
        // Zero-latency pass-through on an empty queue.
        step(1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 0);
        step(1'b0, 32'h00, 32'h00, 1'b0, 1'b0, 0);
`else
        // Without the bypass path, the entry appears one cycle after the push.
        step(1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 0);
        step(1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 1);
        step(1'b0, 32'h00, 32'h00, 1'b0, 1'b0, 0);
`endif

        check("scoreboard empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
